// File: rtl/bus_memory_responder.sv
// Memory-side responder for the multiplexed 8088 minimum-mode bus.
// Latches the address on ALE, decodes a window, and serves reads/writes from a byte array with optional READY wait states.
module bus_memory_responder #(
    parameter int          ADDR_BITS   = 10,
    parameter logic [19:0] BASE_ADDR   = 20'hFFC00,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ale,
    input  logic       iom,
    input  logic [11:0] a,
    input  logic [7:0] ad_in,
    input  logic       rd_n,
    input  logic       wr_n,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       ready,
    output logic       write_done,
    output logic       bus_err
);

    typedef enum logic [2:0] {IDLE, ADDR, WAIT, XFER, HOLD} state_t;

    state_t                 state, state_d;
    logic [19:0]            addr_q, addr_d;
    logic                   iom_q, iom_d;
    logic                   is_wr, is_wr_d;
    logic [3:0]             cnt, cnt_d;
    logic [7:0]             ad_out_d;
    logic                   ad_oe_d, ready_d, write_done_d, bus_err_d;
    logic                   mem_we;
    logic                   sel;
    logic                   strobe_low;
    logic [ADDR_BITS-1:0]   idx;

    logic [7:0] mem [0:(1 << ADDR_BITS) - 1];

    assign sel        = !iom_q && (addr_q[19:ADDR_BITS] == BASE_ADDR[19:ADDR_BITS]);
    assign idx        = addr_q[ADDR_BITS-1:0];
    assign strobe_low = is_wr ? !wr_n : !rd_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            iom_q      <= 1'b0;
            is_wr      <= 1'b0;
            cnt        <= '0;
            ad_out     <= '0;
            ad_oe      <= 1'b0;
            ready      <= 1'b1;
            write_done <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            state      <= state_d;
            addr_q     <= addr_d;
            iom_q      <= iom_d;
            is_wr      <= is_wr_d;
            cnt        <= cnt_d;
            ad_out     <= ad_out_d;
            ad_oe      <= ad_oe_d;
            ready      <= ready_d;
            write_done <= write_done_d;
            bus_err    <= bus_err_d;
        end
    end

    // Array has no reset; a reset in the commit clock suppresses the write.
    always_ff @(posedge clk) begin
        if (mem_we && !rst)
            mem[idx] <= ad_in;
    end

    always_comb begin
        state_d      = state;
        addr_d       = addr_q;
        iom_d        = iom_q;
        is_wr_d      = is_wr;
        cnt_d        = cnt;
        ad_out_d     = ad_out;
        ad_oe_d      = ad_oe;
        ready_d      = ready;
        write_done_d = 1'b0;
        bus_err_d    = 1'b0;
        mem_we       = 1'b0;

        if (ale) begin
            state_d = ADDR;
            addr_d  = {a, ad_in};
            iom_d   = iom;
            ad_oe_d = 1'b0;
            ready_d = 1'b1;
            cnt_d   = '0;
        end else begin
            case (state)
                IDLE: begin
                    ad_oe_d = 1'b0;
                    ready_d = 1'b1;
                end
                ADDR: begin
                    ad_oe_d = 1'b0;
                    ready_d = 1'b1;
                    if (sel) begin
                        if (!rd_n && !wr_n) begin
                            bus_err_d = 1'b1;
                            state_d   = IDLE;
                        end else if (!rd_n || !wr_n) begin
                            is_wr_d = !wr_n;
                            cnt_d   = 4'(WAIT_STATES);
                            if (WAIT_STATES == 0) begin
                                state_d = XFER;
                            end else begin
                                state_d = WAIT;
                                ready_d = 1'b0;
                            end
                        end
                    end
                end
                WAIT: begin
                    if (!strobe_low) begin
                        state_d = IDLE;
                        ready_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            ready_d = 1'b1;
                            state_d = XFER;
                        end
                    end
                end
                XFER: begin
                    if (is_wr) begin
                        mem_we       = 1'b1;
                        write_done_d = 1'b1;
                    end else begin
                        ad_out_d = mem[idx];
                        ad_oe_d  = 1'b1;
                    end
                    state_d = HOLD;
                end
                HOLD: begin
                    if (!strobe_low) begin
                        ad_oe_d = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: doc/bus_memory_responder.md
Name: bus_memory_responder

Overview:
- Minimum-mode 8088 bus slave: the memory end of the multiplexed processor bus.
- Demultiplexes the address on ALE, decodes a memory window, and returns read data on the AD bus with optional wait states via READY.
- Commits write data into an internal byte array.
- Sits beside processor_8088 as the synthesizable ROM/RAM responder, replacing the behavioural bench memory.

Parameters:
- ADDR_BITS, 10, log2 of array depth in bytes (default 1 KiB).
- BASE_ADDR, 20'hFFC00, window base; only bits [19:ADDR_BITS] are compared.
- WAIT_STATES, 0, clocks READY is held low after a strobe is sampled low (0..15).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- ale  input  1  address latch enable from the CPU.
- iom  input  1  1 = I/O cycle, 0 = memory cycle; sampled with ALE.
- a  input  12  upper address a[19:8].
- ad_in  input  8  multiplexed address/data from the CPU side.
- rd_n  input  1  read strobe, active-low.
- wr_n  input  1  write strobe, active-low.
- ad_out  output  8  read data.
- ad_oe  output  1  drive enable for ad_out onto the shared AD bus.
- ready  output  1  CPU READY; low inserts wait states.
- write_done  output  1  one-clock pulse when a write commits to the array.
- bus_err  output  1  one-clock pulse on rd_n and wr_n both sampled low while selected.

Behaviour:
- Reset: all outputs take their reset values on the first clk edge with rst=1: ad_out=0, ad_oe=0, ready=1, write_done=0, bus_err=0, state=IDLE, wait counter=0.
  - Array contents are not reset.
  - rst mid-cycle aborts the transfer. No write commits in that clock.
- Address latch: any clk edge with ale=1 loads addr_q={a,ad_in} and iom_q=iom, and forces state=ADDR. This applies from every state, including aborting WAIT/XFER/HOLD.
  - ad_oe drops to 0 in that same edge.
- Select: sel = (iom_q==0) && (addr_q[19:ADDR_BITS]==BASE_ADDR[19:ADDR_BITS]). Array index = addr_q[ADDR_BITS-1:0].
- States:
  - IDLE: outputs idle.
  - ADDR:
    - If sel=0, the module stays passive: ready=1, ad_oe=0, until the next ALE.
    - If sel=1 and exactly one strobe is sampled low: load counter=WAIT_STATES.
      - If WAIT_STATES==0, go to XFER.
      - Otherwise go to WAIT and drive ready=0 from that edge.
    - If both strobes are sampled low: pulse bus_err, go to IDLE, no access.
  - WAIT:
    - ready=0; the counter decrements each clock.
    - On the edge where the counter reaches 0: ready=1, go to XFER.
    - If the strobe deasserts early: go to IDLE, no transfer.
  - XFER, read:
    - ad_out=mem[index], ad_oe=1 registered (1 clk after entry).
    - Go to HOLD.
  - XFER, write:
    - mem[index]<=ad_in sampled this clock.
    - write_done=1 for exactly one clock.
    - Go to HOLD.
  - HOLD:
    - Read data stays driven while rd_n=0.
    - First clock with the active strobe high: ad_oe=0, ad_out unchanged, go to IDLE.
    - A write commits only once per strobe assertion.
- Latency: with WAIT_STATES=0, read data is valid 2 clocks after rd_n is first sampled low. With N wait states, add N clocks. ready is low for exactly N clocks.
- ready is never low when sel=0 or in IDLE/HOLD.
- Back-to-back cycles: a new ALE in HOLD is legal and starts the next cycle immediately.
- Index wrap: none. The index is exactly ADDR_BITS wide, and addresses outside the window are ignored.

Test Plan:
- Reset with rst=1 for 2 clocks -> ad_oe=0, ready=1, write_done=0, bus_err=0. Preloaded mem[0x3F0]=0xEA is unchanged.
- WAIT_STATES=0: ALE with a=12'hFFF, ad_in=8'hF0, then rd_n low -> ad_out=0xEA, ad_oe=1 two clocks after rd_n low. ad_oe=0 one clock after rd_n high.
- WAIT_STATES=3: write 0x5A to 0xFFC10 -> ready low for exactly 3 clocks, write_done pulses once. A read of 0xFFC10 then returns 0x5A.
- Unselected address 0x00400, and an I/O cycle to 0xFFC00 (iom=1) -> ready stays 1, ad_oe stays 0, no write_done, array unchanged.
- rd_n and wr_n both low after ALE to 0xFFC00 -> single bus_err pulse, no ad_oe, no write.
- Abort cases:
  - Assert rst during WAIT of a write -> no write_done, ready=1 next clock, target byte unchanged.
  - New ALE during HOLD of a read -> ad_oe drops that edge and the new cycle completes normally.
